// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 mux. It holds each grant until the requester
// releases it, with an optional fairness timeout, and drives the mux selects.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16  // 0 disables preemption; otherwise 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [7:0] gnt_n;
  logic [2:0] sel_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] hcnt, hcnt_n;
  logic [7:0] others;
  logic       timeout;

  // First requester at or after base, wrapping modulo 8. The loop runs downward
  // so the nearest index to base is the last one written.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] win;
    win = base;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  // In GRANT, sel always holds the current owner's index.
  assign others  = req & ~(8'd1 << sel);
  assign timeout = (MAX_HOLD != 0) && (hcnt == HOLD_LIM) && en && (|others);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    ptr_n   = ptr;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (en && (|req)) begin
          sel_n   = rr_pick(req, ptr);
          gnt_n   = 8'd1 << sel_n;
          hcnt_n  = 8'd1;
          state_n = GRANT;
        end else begin
          gnt_n = '0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          // The pointer moves past the releasing owner before the search.
          ptr_n = sel + 3'd1;
          if (en && (|req)) begin
            sel_n  = rr_pick(req, sel + 3'd1);
            gnt_n  = 8'd1 << sel_n;
            hcnt_n = 8'd1;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (timeout) begin
          ptr_n  = sel + 3'd1;
          sel_n  = rr_pick(others, sel + 3'd1);
          gnt_n  = 8'd1 << sel_n;
          hcnt_n = 8'd1;
        end else if ((MAX_HOLD != 0) && (hcnt != HOLD_LIM)) begin
          hcnt_n = hcnt + 8'd1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hcnt      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      gnt_valid <= |gnt_n;
      ptr       <= ptr_n;
      hcnt      <= hcnt_n;
    end
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8:1 multiplexer datapath among eight requesters.
- Grants one requester at a time and drives the mux select lines from a registered grant, so the mux output is stable for the whole grant.
- Supports hold-until-release grants with an optional fairness timeout that forces rotation.
- Sits between the requester bank and the mux. Its sel outputs connect to the mux select inputs: sel[0] to s0, sel[1] to s1, sel[2] to s2.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant is held while other requests are pending. Range 0..255. 0 = unlimited (no preemption).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; req[i] high = requester i wants the mux. Held high for the duration of the transfer.
- en  input  1  arbitration enable; low blocks new grants.
- gnt  output  8  one-hot registered grant; all zero when idle.
- sel  output  3  binary index of the current or last grant, driving the mux selects.
- gnt_valid  output  1  high when gnt is non-zero.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n). Assertion immediately forces:
  - gnt = 8'h00, sel = 3'd0, gnt_valid = 0;
  - priority pointer ptr = 0, hold counter hcnt = 0, state IDLE.
  - Deassertion is sampled synchronously; the first arbitration happens on the first rising edge after deassertion.
- All outputs are registered. gnt, sel and gnt_valid always change on the same edge.
- Arbitration function: winner = first index k scanning ptr, ptr+1, …, ptr+7 (mod 8) with req[k] = 1.
- State IDLE:
  - If en = 1 and req != 0: on the next edge, gnt = onehot(winner), sel = winner, gnt_valid = 1, hcnt = 1, go to GRANT.
  - Otherwise stay in IDLE with gnt = 0 and gnt_valid = 0. sel keeps its last value so the mux path stays quiet.
- Request-to-grant latency: 1 cycle.
- State GRANT, current owner c:
  - Release (req[c] = 0): ptr <= c+1 mod 8.
    - If en = 1 and another req bit is set, re-arbitrate from c+1 in the same cycle. The new grant is visible on the next edge (zero-bubble handover) and hcnt = 1.
    - Otherwise: gnt = 0, gnt_valid = 0, go to IDLE.
  - Timeout (req[c] = 1, MAX_HOLD != 0, hcnt == MAX_HOLD, en = 1, some other req bit set): preempt. ptr <= c+1, grant the winner among the others from c+1, hcnt = 1.
    - Requester c is not re-granted until its turn comes round again.
  - Hold (req[c] = 1, no timeout): keep gnt and sel. hcnt increments and saturates at MAX_HOLD (no wrap). With MAX_HOLD = 0, hcnt is unused.
  - If no other request is pending at hcnt == MAX_HOLD, c keeps the grant.
  - If en = 0 during GRANT: the current grant continues until released. Timeout preemption and re-arbitration are suppressed. On release, go to IDLE.
- Invariants:
  - gnt is never multi-hot.
  - gnt[i] is never high in a cycle where req[i] was low on the previous edge, except for the one-cycle release latency.
  - sel == index of the set gnt bit whenever gnt_valid = 1.
- Simultaneous events: a release and a new request arriving in the same cycle are handled as a release with re-arbitration. The pointer update always precedes the winner search in that cycle.
- Reset mid-grant: outputs drop immediately (asynchronously). ptr returns to 0.

Test Plan:
- Reset/idle: rst_n = 0 with req = 8'hFF → gnt = 0, sel = 0, gnt_valid = 0. Release reset with en = 1 → next edge gnt = 8'h01, sel = 0.
- Rotation: req = 8'hFF held, each owner drops its req for 1 cycle after 2 cycles → grant order 0,1,2,…,7,0, sel tracks the order, no idle cycles between grants.
- Timeout: MAX_HOLD = 4, req = 8'h05 held continuously → gnt = 01 for 4 cycles, then 04 for 4 cycles, then 01 again. With req = 8'h01 alone → gnt = 01 held indefinitely.
- Unlimited hold: MAX_HOLD = 0, req = 8'h81 held for 100 cycles → gnt = 01 throughout. Drop req[0] → gnt = 80, sel = 7 on the next edge.
- Enable gating: en = 0, req = 8'h10 → gnt stays 0. Set en = 1 → next edge gnt = 10, sel = 4. Clear en while held, then release req[4] with req[5] set → gnt = 0 and state returns to IDLE.
- Async reset mid-grant: gnt = 08, pulse rst_n low between clock edges → gnt/gnt_valid drop immediately. After release, req = 8'h0C yields gnt = 04 (ptr back to 0).
